// File: rtl/result_fifo_st_to_mm.sv
// result_fifo_st_to_mm
//
// Return path for accelerator results. 32-bit words arrive on an Avalon-ST
// sink and are buffered in a DEPTH-entry circular FIFO. The HPS reads them
// through an Avalon-MM slave.
//
// Words are byte-swapped on the way in, matching the instruction FIFO, so a
// word the HPS wrote as bytes B3..B0 comes back unchanged.
//
// Register map:
//   0 DATA     pop-on-read. Stalls with waitrequest while the FIFO is empty.
//   1 STATUS   [AW:0] count, [16] empty, [17] full, [18] underflow_seen
//   2 CONTROL  reads 0. On write, bit0 flushes the FIFO and bit1 clears
//              underflow_seen.
//   3          reserved, reads 0
//
// Ports:
//   clock, reset_n                     single clock, async active-low reset
//   avalonst_sink_data/valid/ready     result stream in (ready latency 0)
//   avalonmm_read_slave_address        register select
//   avalonmm_read_slave_read/write     access strobes (read wins if both set)
//   avalonmm_read_slave_writedata      CONTROL write data
//   avalonmm_read_slave_readdata       registered read data, latency 1
//   avalonmm_read_slave_readdatavalid  one-cycle pulse per accepted read
//   avalonmm_read_slave_waitrequest    stall for a DATA read while empty
module result_fifo_st_to_mm #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] avalonst_sink_data,
    input  logic        avalonst_sink_valid,
    output logic        avalonst_sink_ready,
    input  logic [1:0]  avalonmm_read_slave_address,
    input  logic        avalonmm_read_slave_read,
    input  logic        avalonmm_read_slave_write,
    input  logic [31:0] avalonmm_read_slave_writedata,
    output logic [31:0] avalonmm_read_slave_readdata,
    output logic        avalonmm_read_slave_readdatavalid,
    output logic        avalonmm_read_slave_waitrequest
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Same lane swap as the instruction FIFO; it is its own inverse.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          underflow_seen;
    logic [31:0]   readdata_p1;
    logic          vld_p1;

    logic        empty;
    logic        full;
    logic        data_rd;
    logic        rd_accept;
    logic        push;
    logic        pop;
    logic        ctrl_wr;
    logic        flush;
    logic        clr_underflow;
    logic [31:0] status;

    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_COUNT);

        // Ready depends only on the registered count, never on a same-cycle
        // pop, which keeps the sink free of a combinational path from the MM side.
        avalonst_sink_ready = reset_n & ~full;

        data_rd = avalonmm_read_slave_read & (avalonmm_read_slave_address == 2'd0);
        avalonmm_read_slave_waitrequest = ~reset_n | (data_rd & empty);

        rd_accept = avalonmm_read_slave_read & ~avalonmm_read_slave_waitrequest;
        pop       = rd_accept & (avalonmm_read_slave_address == 2'd0);
        push      = avalonst_sink_valid & avalonst_sink_ready;

        // A write issued together with a read is ignored.
        ctrl_wr       = avalonmm_read_slave_write & ~avalonmm_read_slave_read &
                        (avalonmm_read_slave_address == 2'd2);
        flush         = ctrl_wr & avalonmm_read_slave_writedata[0];
        clr_underflow = ctrl_wr & avalonmm_read_slave_writedata[1];

        status       = '0;
        status[AW:0] = count;
        status[16]   = empty;
        status[17]   = full;
        status[18]   = underflow_seen;
    end

    // Storage array: contents need no reset, the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= byte_swap(avalonst_sink_data);
        end
    end

    // Stage p0 -> p1: pointer/count update and registered read response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            underflow_seen <= 1'b0;
            readdata_p1    <= '0;
            vld_p1         <= 1'b0;
        end else begin
            if (flush) begin
                // Flush wins over any push or pop in the same cycle.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Sticky marker for software to spot a DATA read hung on empty.
            if (data_rd && empty) begin
                underflow_seen <= 1'b1;
            end else if (clr_underflow) begin
                underflow_seen <= 1'b0;
            end

            vld_p1 <= rd_accept;
            if (rd_accept) begin
                case (avalonmm_read_slave_address)
                    2'd0:    readdata_p1 <= mem[rd_ptr];
                    2'd1:    readdata_p1 <= status;
                    default: readdata_p1 <= '0;
                endcase
            end
        end
    end

    assign avalonmm_read_slave_readdata      = readdata_p1;
    assign avalonmm_read_slave_readdatavalid = vld_p1;

endmodule

// File: tb/tb_result_fifo_st_to_mm.sv
// Self-checking bench for result_fifo_st_to_mm: a table of directed vectors,
// hand-written corner sequences and a randomized phase, all compared against
// a queue-based reference model of the FIFO.
module tb_result_fifo_st_to_mm;

    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic        clock;
    logic        reset_n;
    logic [31:0] sink_data;
    logic        sink_valid;
    logic        sink_ready;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] q[$];
    logic        uf_model;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        rd;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_rdv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    result_fifo_st_to_mm #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock                             (clock),
        .reset_n                           (reset_n),
        .avalonst_sink_data                (sink_data),
        .avalonst_sink_valid               (sink_valid),
        .avalonst_sink_ready               (sink_ready),
        .avalonmm_read_slave_address       (address),
        .avalonmm_read_slave_read          (read),
        .avalonmm_read_slave_write         (write),
        .avalonmm_read_slave_writedata     (writedata),
        .avalonmm_read_slave_readdata      (readdata),
        .avalonmm_read_slave_readdatavalid (readdatavalid),
        .avalonmm_read_slave_waitrequest   (waitrequest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = d[8*(3-b) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = q.size();
        return 32'(n) | ((n == 0) ? 32'h0001_0000 : 32'h0)
                      | ((n == DEPTH) ? 32'h0002_0000 : 32'h0)
                      | (uf_model ? 32'h0004_0000 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: entered and left at posedge+1. Drives the inputs,
    // checks the combinational handshakes against the model mid-cycle, then
    // checks the registered response after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic rd,
                        input logic [1:0] a, input logic wr, input logic [31:0] wd);
        logic        exp_ready, exp_wait, acc, pop, push, flush, clr;
        logic [31:0] exp_rd;
        sink_valid = v;
        sink_data  = d;
        read       = rd;
        address    = a;
        write      = wr;
        writedata  = wd;
        #3;
        exp_ready = (q.size() != DEPTH);
        exp_wait  = rd && (a == 2'd0) && (q.size() == 0);
        chk("sink_ready", {31'b0, sink_ready}, {31'b0, exp_ready});
        chk("waitrequest", {31'b0, waitrequest}, {31'b0, exp_wait});
        push  = v && exp_ready;
        acc   = rd && !exp_wait;
        pop   = acc && (a == 2'd0);
        flush = wr && !rd && (a == 2'd2) && wd[0];
        clr   = wr && !rd && (a == 2'd2) && wd[1];
        exp_rd = 32'h0;
        if (acc) begin
            if (a == 2'd0)      exp_rd = q[0];
            else if (a == 2'd1) exp_rd = model_status();
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(swap32(d));
        end
        if (exp_wait)  uf_model = 1'b1;
        else if (clr)  uf_model = 1'b0;
        @(posedge clock);
        #1;
        chk("readdatavalid", {31'b0, readdatavalid}, {31'b0, acc});
        if (acc) chk("readdata", readdata, exp_rd);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // valid, data, rd, addr, wr, wdata, exp_rdv, exp_rdata
        vecs[0] = '{1'b1, 32'h1122_3344, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 32'h4433_2211};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0001_0000};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 2'd2, 1'b1, 32'h3,  1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0001_0000};
        vecs[7] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,         1'b1, 2'd1, 1'b0, 32'h0, 1'b1, 32'h0000_0001};
        vecs[9] = '{1'b0, 32'h0,         1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 32'hEFBE_ADDE};

        uf_model   = 1'b0;
        reset_n    = 1'b0;
        sink_valid = 1'b0;
        sink_data  = '0;
        read       = 1'b0;
        address    = '0;
        write      = 1'b0;
        writedata  = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_sink_ready", {31'b0, sink_ready}, 32'h0);
        chk("rst_waitrequest", {31'b0, waitrequest}, 32'h1);
        chk("rst_readdatavalid", {31'b0, readdatavalid}, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_after_reset", readdata, 32'h0001_0000);

        // Table-driven register map / byte swap vectors
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].rd, vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdv", i), {31'b0, readdatavalid}, {31'b0, vecs[i].exp_rdv});
            if (vecs[i].exp_rdv) chk($sformatf("vec%0d_rdata", i), readdata, vecs[i].exp_rdata);
        end

        // Fill to full, then drain across pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'h999, 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_full", readdata, 32'h0002_0080);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
            chk("drain_order", readdata, swap32(32'(i)));
        end

        // Stalled read on empty, released by a push
        repeat (5) step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hA5A5_A5A5, 1'b1, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        chk("stall_release_data", readdata, 32'hA5A5_A5A5);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_underflow", readdata, 32'h0005_0000);
        step(1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 32'h2);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_uf_cleared", readdata, 32'h0001_0000);

        // Full with valid held while popping, then steady push+pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'h1000, 1'b1, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'h1001, 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_refull", readdata, 32'h0002_0080);
        repeat (DEPTH/2) step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        repeat (50) step(1'b1, $urandom, 1'b1, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_halffull", readdata, 32'h0000_0040);

        // Flush with 20 words buffered
        step(1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 32'h1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i + 100), 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 2'd2, 1'b1, 32'h1);
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_flushed", readdata, 32'h0001_0000);
        step(1'b1, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0);
        chk("data_after_flush", readdata, 32'h0DF0_FECA);

        // Reset mid-burst with a read response in flight
        for (int i = 0; i < 11; i++) step(1'b1, $urandom, 1'b0, 2'd0, 1'b0, 32'h0);
        sink_valid = 1'b1;
        read       = 1'b1;
        address    = 2'd0;
        @(posedge clock);
        #1;
        chk("inflight_rdv", {31'b0, readdatavalid}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_sink_ready", {31'b0, sink_ready}, 32'h0);
        chk("midrst_waitrequest", {31'b0, waitrequest}, 32'h1);
        chk("midrst_readdatavalid", {31'b0, readdatavalid}, 32'h0);
        chk("midrst_readdata", readdata, 32'h0);
        q.delete();
        uf_model   = 1'b0;
        sink_valid = 1'b0;
        read       = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_held_rdv", {31'b0, readdatavalid}, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
        chk("status_after_midrst", readdata, 32'h0001_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        v, rd, wr;
            logic [1:0]  a;
            logic [31:0] wd;
            v  = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            rd = $urandom_range(0, 2) == 0;
            a  = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
            wr = $urandom_range(0, 24) == 0;
            wd = {30'h0, 2'($urandom_range(0, 3))};
            if (wr && !rd) a = ($urandom_range(0, 1) == 0) ? 2'd2 : a;
            step(v, $urandom, rd, a, wr, wd);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
